// File: rtl/forward_ctrl_unit.sv
// EXE-stage forwarding control: shadow EXE/MEM/WB destinations, operand selects, load-use stalls.
// Macro FORW_CTRL_FORWARDING_EN enables forwarding; undefined builds interlock on every hazard.
module forward_ctrl_unit #(
  parameter int unsigned REG_ADDR_LEN = 5,
  parameter int unsigned SEL_LEN      = 2,
  parameter int unsigned CNT_LEN      = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_id_valid,
  input  logic [REG_ADDR_LEN-1:0] i_id_src1,
  input  logic [REG_ADDR_LEN-1:0] i_id_src2,
  input  logic                    i_id_use_src2,
  input  logic                    i_id_is_store,
  input  logic [REG_ADDR_LEN-1:0] i_id_st_src,
  input  logic [REG_ADDR_LEN-1:0] i_id_dest,
  input  logic                    i_id_wb_en,
  input  logic                    i_id_mem_read,
  input  logic                    i_flush,
  output logic                    o_stall,
  output logic [SEL_LEN-1:0]      o_val1_sel,
  output logic [SEL_LEN-1:0]      o_val2_sel,
  output logic [SEL_LEN-1:0]      o_st_val_sel,
  output logic [CNT_LEN-1:0]      o_stall_count
);

  logic                    r_exe_valid, r_exe_wb_en, r_exe_mem_read;
  logic [REG_ADDR_LEN-1:0] r_exe_dest;
  logic                    r_mem_valid, r_mem_wb_en, r_mem_mem_read;
  logic [REG_ADDR_LEN-1:0] r_mem_dest;
  logic                    r_wb_valid, r_wb_wb_en, r_wb_mem_read;
  logic [REG_ADDR_LEN-1:0] r_wb_dest;
  logic [CNT_LEN-1:0]      r_stall_count;

  logic w_stall, w_issue;
  logic w_exe_m1, w_exe_m2, w_exe_mst, w_exe_hit;
  logic w_mem_m1, w_mem_m2, w_mem_mst, w_mem_hit;

  function automatic logic f_match(input logic                    valid,
                                   input logic                    wb_en,
                                   input logic [REG_ADDR_LEN-1:0] dest,
                                   input logic [REG_ADDR_LEN-1:0] src);
    return valid & wb_en & (dest == src) & (src != '0);
  endfunction

  assign w_exe_m1  = f_match(r_exe_valid, r_exe_wb_en, r_exe_dest, i_id_src1);
  assign w_exe_m2  = f_match(r_exe_valid, r_exe_wb_en, r_exe_dest, i_id_src2);
  assign w_exe_mst = f_match(r_exe_valid, r_exe_wb_en, r_exe_dest, i_id_st_src);
  assign w_mem_m1  = f_match(r_mem_valid, r_mem_wb_en, r_mem_dest, i_id_src1);
  assign w_mem_m2  = f_match(r_mem_valid, r_mem_wb_en, r_mem_dest, i_id_src2);
  assign w_mem_mst = f_match(r_mem_valid, r_mem_wb_en, r_mem_dest, i_id_st_src);

  // src1 is always consumed; src2 and the store source only when the instruction uses them
  assign w_exe_hit = w_exe_m1 | (i_id_use_src2 & w_exe_m2) | (i_id_is_store & w_exe_mst);
  assign w_mem_hit = w_mem_m1 | (i_id_use_src2 & w_mem_m2) | (i_id_is_store & w_mem_mst);

  assign w_issue = i_id_valid & ~w_stall & ~i_flush;

`ifdef FORW_CTRL_FORWARDING_EN
  localparam logic [SEL_LEN-1:0] SelMem = SEL_LEN'(1);
  localparam logic [SEL_LEN-1:0] SelWb  = SEL_LEN'(2);

  logic [SEL_LEN-1:0] r_val1_sel, r_val2_sel, r_st_val_sel;
  logic [SEL_LEN-1:0] w_val1_sel, w_val2_sel, w_st_val_sel;
  logic               w_unused;

  // Youngest producer wins: EXE now means MEM when the consumer reaches EXE
  function automatic logic [SEL_LEN-1:0] f_sel(input logic exe_m, input logic mem_m);
    if (exe_m) return SelMem;
    if (mem_m) return SelWb;
    return '0;
  endfunction

  assign w_stall      = i_id_valid & ~i_flush & r_exe_mem_read & w_exe_hit;
  assign w_val1_sel   = f_sel(w_exe_m1, w_mem_m1);
  assign w_val2_sel   = i_id_use_src2 ? f_sel(w_exe_m2, w_mem_m2) : '0;
  assign w_st_val_sel = i_id_is_store ? f_sel(w_exe_mst, w_mem_mst) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_val1_sel   <= '0;
      r_val2_sel   <= '0;
      r_st_val_sel <= '0;
    end else if (w_issue) begin
      r_val1_sel   <= w_val1_sel;
      r_val2_sel   <= w_val2_sel;
      r_st_val_sel <= w_st_val_sel;
    end else begin
      r_val1_sel   <= '0;
      r_val2_sel   <= '0;
      r_st_val_sel <= '0;
    end
  end

  assign o_val1_sel   = r_val1_sel;
  assign o_val2_sel   = r_val2_sel;
  assign o_st_val_sel = r_st_val_sel;
  assign w_unused     = ^{r_wb_valid, r_wb_wb_en, r_wb_dest, r_wb_mem_read};
`else
  logic w_wb_hit;
  logic w_unused;

  // Register file is written at the end of WB, so a WB producer still blocks the read in ID
  assign w_wb_hit =
      f_match(r_wb_valid, r_wb_wb_en, r_wb_dest, i_id_src1) |
      (i_id_use_src2 & f_match(r_wb_valid, r_wb_wb_en, r_wb_dest, i_id_src2)) |
      (i_id_is_store & f_match(r_wb_valid, r_wb_wb_en, r_wb_dest, i_id_st_src));

  assign w_stall      = i_id_valid & ~i_flush & (w_exe_hit | w_mem_hit | w_wb_hit);
  assign o_val1_sel   = '0;
  assign o_val2_sel   = '0;
  assign o_st_val_sel = '0;
  assign w_unused     = r_wb_mem_read;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exe_valid    <= 1'b0;
      r_exe_wb_en    <= 1'b0;
      r_exe_mem_read <= 1'b0;
      r_exe_dest     <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_wb_en    <= 1'b0;
      r_mem_mem_read <= 1'b0;
      r_mem_dest     <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_wb_en     <= 1'b0;
      r_wb_mem_read  <= 1'b0;
      r_wb_dest      <= '0;
    end else begin
      r_exe_valid    <= w_issue;
      r_exe_wb_en    <= i_id_wb_en & w_issue;
      r_exe_mem_read <= i_id_mem_read & w_issue;
      r_exe_dest     <= i_id_dest;
      r_mem_valid    <= r_exe_valid;
      r_mem_wb_en    <= r_exe_wb_en;
      r_mem_mem_read <= r_exe_mem_read;
      r_mem_dest     <= r_exe_dest;
      r_wb_valid     <= r_mem_valid;
      r_wb_wb_en     <= r_mem_wb_en;
      r_wb_mem_read  <= r_mem_mem_read;
      r_wb_dest      <= r_mem_dest;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_LEN'(1);
    end
  end

  assign o_stall       = w_stall;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Directed vector bench for forward_ctrl_unit; expectations follow FORW_CTRL_FORWARDING_EN.
module tb_forward_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_use_src2 = 1'b0, id_is_store = 1'b0;
  logic       id_wb_en = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic [4:0] id_src1 = '0, id_src2 = '0, id_st_src = '0, id_dest = '0;
  logic       stall;
  logic [1:0] val1_sel, val2_sel, st_val_sel;
  logic [3:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  forward_ctrl_unit #(
    .REG_ADDR_LEN(5),
    .SEL_LEN     (2),
    .CNT_LEN     (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_id_valid   (id_valid),
    .i_id_src1    (id_src1),
    .i_id_src2    (id_src2),
    .i_id_use_src2(id_use_src2),
    .i_id_is_store(id_is_store),
    .i_id_st_src  (id_st_src),
    .i_id_dest    (id_dest),
    .i_id_wb_en   (id_wb_en),
    .i_id_mem_read(id_mem_read),
    .i_flush      (flush),
    .o_stall      (stall),
    .o_val1_sel   (val1_sel),
    .o_val2_sel   (val2_sel),
    .o_st_val_sel (st_val_sel),
    .o_stall_count(stall_count)
  );

  typedef struct {
    logic       rst, valid;
    logic [4:0] s1, s2;
    logic       use2, st;
    logic [4:0] sts, dest;
    logic       wb, mrd, flush;
    logic       e_stall;
    logic [1:0] e1, e2, est;
    logic [3:0] e_cnt;
  } vec_t;

  function automatic vec_t v(input logic r, va, input logic [4:0] s1, s2,
                             input logic u2, st, input logic [4:0] sts, d,
                             input logic wb, mr, fl, es,
                             input logic [1:0] e1, e2, est, input logic [3:0] ec);
    vec_t t;
    t.rst = r; t.valid = va; t.s1 = s1; t.s2 = s2; t.use2 = u2; t.st = st;
    t.sts = sts; t.dest = d; t.wb = wb; t.mrd = mr; t.flush = fl;
    t.e_stall = es; t.e1 = e1; t.e2 = e2; t.est = est; t.e_cnt = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive at negedge, check combinational stall before the edge, registered outputs after
  task automatic step(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.rst; id_valid = t.valid; id_src1 = t.s1; id_src2 = t.s2;
    id_use_src2 = t.use2; id_is_store = t.st; id_st_src = t.sts; id_dest = t.dest;
    id_wb_en = t.wb; id_mem_read = t.mrd; flush = t.flush;
    #1;
    check({tag, ".stall"}, 16'(stall), 16'(t.e_stall));
    @(posedge clk);
    #1;
    check({tag, ".val1_sel"}, 16'(val1_sel), 16'(t.e1));
    check({tag, ".val2_sel"}, 16'(val2_sel), 16'(t.e2));
    check({tag, ".st_val_sel"}, 16'(st_val_sel), 16'(t.est));
    check({tag, ".stall_count"}, 16'(stall_count), 16'(t.e_cnt));
  endtask

  initial begin
    vec_t tbl[$];
    int   exp_cnt;
    int   nstall;
    logic [1:0] dep_sel;

    tbl.push_back(v(1,0, 0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0));  // reset cycle 1
    tbl.push_back(v(1,0, 0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0));  // reset cycle 2
`ifdef FORW_CTRL_FORWARDING_EN
    nstall  = 1;
    dep_sel = 2'd2;
    tbl.push_back(v(0,1, 1,2,1,0, 0,3,1,0,0, 0, 0,0,0, 0));  // ADD r3
    tbl.push_back(v(0,1, 3,2,1,0, 0,10,1,0,0, 0, 1,0,0, 0)); // SUB r3 back-to-back
    tbl.push_back(v(0,0, 0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0));  // NOP
    tbl.push_back(v(0,1, 1,2,1,0, 0,3,1,0,0, 0, 0,0,0, 0));  // ADD r3
    tbl.push_back(v(0,0, 0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0));  // NOP
    tbl.push_back(v(0,1, 3,3,0,0, 0,11,1,0,0, 0, 2,0,0, 0)); // ADDI r3, imm
    tbl.push_back(v(0,1, 11,0,0,1, 11,0,0,0,0, 0, 1,0,1, 0)); // ST same src twice
    tbl.push_back(v(0,1, 1,0,0,0, 0,4,1,1,0, 0, 0,0,0, 0));  // LD r4
    tbl.push_back(v(0,1, 1,4,1,0, 0,12,1,0,0, 1, 0,0,0, 1)); // load-use stall
    tbl.push_back(v(0,1, 1,4,1,0, 0,12,1,0,0, 0, 0,2,0, 1)); // no re-stall, sel 2
    tbl.push_back(v(0,1, 1,0,0,0, 0,4,1,1,0, 0, 0,0,0, 1));  // LD r4
    tbl.push_back(v(0,1, 1,4,1,0, 0,12,1,0,1, 0, 0,0,0, 1)); // dependent, flushed
    tbl.push_back(v(0,0, 0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 1));  // NOP
    tbl.push_back(v(0,1, 1,0,0,0, 0,0,1,1,0, 0, 0,0,0, 1));  // LD r0
    tbl.push_back(v(0,1, 0,0,1,0, 0,13,1,0,0, 0, 0,0,0, 1)); // reads r0
    tbl.push_back(v(0,1, 1,2,1,0, 0,5,1,0,0, 0, 0,0,0, 1));  // ADD r5
    tbl.push_back(v(0,1, 1,2,1,0, 0,5,1,0,0, 0, 0,0,0, 1));  // ADD r5 again
    tbl.push_back(v(0,1, 5,1,1,0, 0,13,1,0,0, 0, 1,0,0, 1)); // EXE beats MEM
    tbl.push_back(v(0,1, 1,5,0,0, 5,0,0,0,0, 0, 0,0,0, 1));  // unused src2/st gated
    tbl.push_back(v(0,1, 1,0,0,0, 0,6,1,1,0, 0, 0,0,0, 1));  // LD r6
    tbl.push_back(v(1,1, 6,0,0,0, 0,0,0,0,0, 1, 0,0,0, 0));  // reset mid-stall
    tbl.push_back(v(0,1, 6,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0));  // shadows cleared
`else
    nstall  = 3;
    dep_sel = 2'd0;
    tbl.push_back(v(0,1, 1,2,1,0, 0,5,1,0,0, 0, 0,0,0, 0));  // ADD r5
    tbl.push_back(v(0,1, 1,0,0,1, 5,0,0,0,0, 1, 0,0,0, 1));  // ST r5: EXE hit
    tbl.push_back(v(0,1, 1,0,0,1, 5,0,0,0,0, 1, 0,0,0, 2));  // MEM hit
    tbl.push_back(v(0,1, 1,0,0,1, 5,0,0,0,0, 1, 0,0,0, 3));  // WB hit
    tbl.push_back(v(0,1, 1,0,0,1, 5,0,0,0,0, 0, 0,0,0, 3));  // released
    tbl.push_back(v(0,1, 1,2,1,0, 0,3,1,0,0, 0, 0,0,0, 3));  // ADD r3
    tbl.push_back(v(0,1, 3,3,0,0, 0,0,1,0,0, 1, 0,0,0, 4));  // ADDI r3 -> r0
    tbl.push_back(v(0,1, 3,3,0,0, 0,0,1,0,0, 1, 0,0,0, 5));
    tbl.push_back(v(0,1, 3,3,0,0, 0,0,1,0,0, 1, 0,0,0, 6));
    tbl.push_back(v(0,1, 3,3,0,0, 0,0,1,0,0, 0, 0,0,0, 6));
    tbl.push_back(v(0,1, 0,0,1,0, 0,6,1,0,0, 0, 0,0,0, 6));  // reads r0
    tbl.push_back(v(0,1, 6,0,0,0, 0,0,0,0,1, 0, 0,0,0, 6));  // flushed
    tbl.push_back(v(0,1, 6,0,0,0, 0,0,0,0,0, 1, 0,0,0, 7));  // MEM hit
    tbl.push_back(v(0,0, 6,0,0,0, 0,0,0,0,0, 0, 0,0,0, 7));  // invalid ID
    tbl.push_back(v(0,1, 1,2,1,0, 0,7,1,0,0, 0, 0,0,0, 7));  // ADD r7
    tbl.push_back(v(1,1, 7,0,0,0, 0,0,0,0,0, 1, 0,0,0, 0));  // reset mid-stall
    tbl.push_back(v(0,1, 7,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0));  // shadows cleared
    tbl.push_back(v(0,1, 1,2,1,0, 0,8,1,0,0, 0, 0,0,0, 0));  // ADD r8
    tbl.push_back(v(0,1, 1,8,0,0, 8,0,0,0,0, 0, 0,0,0, 0));  // src2/st unused
    tbl.push_back(v(0,1, 1,8,1,0, 0,0,0,0,0, 1, 0,0,0, 1));  // src2 used: MEM hit
    tbl.push_back(v(0,1, 1,8,1,0, 0,0,0,0,0, 1, 0,0,0, 2));  // WB hit
    tbl.push_back(v(0,1, 1,8,1,0, 0,0,0,0,0, 0, 0,0,0, 2));
`endif

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Counter saturation: repeated producer/consumer pairs drive it past all-ones
    step(v(1,0, 0,0,0,0, 0,0,0,0,0, 0, 0,0,0, 0), "sat_rst");
    exp_cnt = 0;
    for (int k = 0; k < 18; k++) begin
      step(v(0,1, 1,0,0,0, 0,9,1,1,0, 0, 0,0,0, 4'(exp_cnt)), $sformatf("sat%0d.prod", k));
      for (int s = 0; s < nstall; s++) begin
        if (exp_cnt < 15) exp_cnt++;
        step(v(0,1, 9,0,0,0, 0,0,0,0,0, 1, 0,0,0, 4'(exp_cnt)), $sformatf("sat%0d.stall%0d", k, s));
      end
      step(v(0,1, 9,0,0,0, 0,0,0,0,0, 0, dep_sel,0,0, 4'(exp_cnt)), $sformatf("sat%0d.go", k));
    end
    check("sat_final", 16'(stall_count), 16'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
